// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter: fixed adder width, word type and response-slot state.
package adder_arb_pkg;
    localparam int ADD_W = 32;

    typedef logic [ADD_W-1:0] word_t;

    typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/adder.sv
// Fixed 32-bit combinational adder shared by the datapath units.
module adder
    import adder_arb_pkg::*;
(
    input  word_t a,
    input  word_t b,
    output word_t q
);
    assign q = a + b;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins, with wrap.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);
    always_comb begin
        int idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        // Walk from ptr upwards; modulo handles non-power-of-two N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
                gnt[idx] = enable;
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one 32-bit adder among N_REQ requesters with round-robin grant and a
// single registered response slot carrying the requester ID and carry-out.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 32,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_q,
    output logic                   rsp_carry
);
    slot_state_t      state, state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             can_accept;
    logic             accept;
    word_t            op_a, op_b, sum;
    logic [ADD_W:0]   wide_sum;

    assign can_accept = (state == EMPTY) || rsp_ready;

    // rst_n gates the enable so no grant is visible while reset is held.
    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .enable  (can_accept && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    assign op_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign op_b = req_b[gnt_idx*WIDTH +: WIDTH];

    adder u_adder (
        .a (op_a),
        .b (op_b),
        .q (sum)
    );

    // The shared adder has no carry-out, so recover it from a parallel wide add.
    assign wide_sum = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rsp_valid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) state_next = FULL;
            end
            FULL: begin
                rsp_valid = 1'b1;
                if (rsp_ready && !accept) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q     <= '0;
            rsp_id    <= '0;
            rsp_carry <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            rsp_q     <= sum;
            rsp_id    <= gnt_idx;
            rsp_carry <= wide_sum[ADD_W];
            rr_ptr    <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter with four requesters.
module tb_adder_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_q;
    logic           rsp_carry;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_carry (rsp_carry)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        #12;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_q !== 32'd0) begin errors++; $display("FAIL reset_q got %h exp 0", rsp_q); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", rsp_carry); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        step();
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single;
        set_ops(0, 32'd1, 32'd2);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_q !== 32'd3) begin errors++; $display("FAIL single_q got %0d exp 3", rsp_q); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL single_carry got %b exp 0", rsp_carry); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_q !== 32'd3) begin errors++; $display("FAIL drain_hold_q got %0d exp 3", rsp_q); end
    endtask

    task automatic test_round_robin;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_ops(i, 32'(15499 + i), 32'd1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % N;
            checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << g)); end
            step();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, rsp_valid); end
            checks++; if (rsp_id !== 2'(g)) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, rsp_id, g); end
            checks++; if (rsp_q !== 32'(15500 + g)) begin errors++; $display("FAIL rr_q[%0d] got %0d exp %0d", k, rsp_q, 15500 + g); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_carry;
        set_ops(2, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry1_ready got %b exp 0100", req_ready); end
        step();
        checks++; if (rsp_q !== 32'h8000_0000) begin errors++; $display("FAIL carry1_q got %h exp 80000000", rsp_q); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL carry1_carry got %b exp 0", rsp_carry); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL carry1_id got %0d exp 2", rsp_id); end
        set_ops(2, 32'hFFFF_FFFF, 32'd1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry2_ready got %b exp 0100", req_ready); end
        step();
        checks++; if (rsp_q !== 32'd0) begin errors++; $display("FAIL carry2_q got %h exp 0", rsp_q); end
        checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL carry2_carry got %b exp 1", rsp_carry); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL carry2_valid got %b exp 1", rsp_valid); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_back_pressure;
        set_ops(1, 32'd120000, 32'd240000);
        set_ops(3, 32'd7, 32'd8);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready got %b exp 0010", req_ready); end
        step();
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, rsp_valid); end
            checks++; if (rsp_q !== 32'd360000) begin errors++; $display("FAIL bp_q[%0d] got %0d exp 360000", c, rsp_q); end
            checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id[%0d] got %0d exp 1", c, rsp_id); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_q !== 32'd15) begin errors++; $display("FAIL bp_next_q got %0d exp 15", rsp_q); end
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL bp_next_id got %0d exp 3", rsp_id); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_mid;
        set_ops(0, 32'd5, 32'd6);
        set_ops(3, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b1001;
        checks++; if (rsp_valid !== 1'b1 || rsp_q !== 32'd11) begin errors++; $display("FAIL mid_full got valid=%b q=%0d exp valid=1 q=11", rsp_valid, rsp_q); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_q !== 32'd0) begin errors++; $display("FAIL mid_q got %0d exp 0", rsp_q); end
        checks++; if (rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL mid_id_carry got id=%0d c=%b exp 0 0", rsp_id, rsp_carry); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", req_ready); end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_id !== 2'd0 || rsp_q !== 32'd11) begin errors++; $display("FAIL mid_after got id=%0d q=%0d exp id=0 q=11", rsp_id, rsp_q); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_carry();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
